// File: rtl/hls_sobel_deadlock_report_ctrl.sv
// Deadlock report controller for the Sobel AXI-stream top.
// Confirms a sustained monitor block flag, snapshots the idle/block vectors
// with the onset timestamp, hands one report to a valid/ready consumer and
// then holds a sticky deadlock flag until cleared.
module hls_sobel_deadlock_report_ctrl #(
  parameter int NUM_PROC       = 7,
  parameter int NUM_AXIS       = 4,
  parameter int CONFIRM_CYCLES = 256,
  parameter int STAMP_W        = 32
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    enable,
  input  logic                                    clear,
  input  logic                                    block_in,
  input  logic [2*NUM_PROC-1:0]                   inst_idle_sigs,
  input  logic [NUM_PROC-1:0]                     inst_block_sigs,
  input  logic [NUM_AXIS-1:0]                     axis_block_sigs,
  output logic                                    report_valid,
  input  logic                                    report_ready,
  output logic [STAMP_W+NUM_AXIS+3*NUM_PROC-1:0]  report_data,
  output logic                                    deadlock_detected,
  output logic [7:0]                              deadlock_count,
  output logic [2:0]                              state_dbg
);

  localparam int          DATA_W   = STAMP_W + NUM_AXIS + 3*NUM_PROC;
  localparam logic [15:0] CNT_LAST = 16'(CONFIRM_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MONITOR = 3'd1,
    S_CONFIRM = 3'd2,
    S_REPORT  = 3'd3,
    S_LATCHED = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [STAMP_W-1:0]  stamp_q, stamp_d;
  logic [STAMP_W-1:0]  onset_q, onset_d;
  logic                report_valid_q, report_valid_d;
  logic [DATA_W-1:0]   report_data_q, report_data_d;
  logic                detected_q, detected_d;
  logic [7:0]          count_q, count_d;

  // Next-state logic: clear overrides every transition, otherwise walk the FSM.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stamp_d        = stamp_q + {{(STAMP_W-1){1'b0}}, 1'b1};
    onset_d        = onset_q;
    report_valid_d = report_valid_q;
    report_data_d  = report_data_q;
    detected_d     = detected_q;
    count_d        = count_q;

    if (clear) begin
      // A pending report is dropped; the confirm window restarts next edge at the earliest.
      report_valid_d = 1'b0;
      detected_d     = 1'b0;
      cnt_d          = 16'd0;
      state_d        = enable ? S_MONITOR : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (enable) state_d = S_MONITOR;
        end
        S_MONITOR: begin
          if (!enable) begin
            state_d = S_IDLE;
          end else if (block_in) begin
            state_d = S_CONFIRM;
            cnt_d   = 16'd1;
            onset_d = stamp_q;
          end
        end
        S_CONFIRM: begin
          if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
          end else if (!block_in) begin
            state_d = S_MONITOR;
            cnt_d   = 16'd0;
          end else if (cnt_q == CNT_LAST) begin
            state_d        = S_REPORT;
            cnt_d          = 16'd0;
            report_data_d  = {onset_q, axis_block_sigs, inst_block_sigs, inst_idle_sigs};
            report_valid_d = 1'b1;
            detected_d     = 1'b1;
            count_d        = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_REPORT: begin
          if (report_ready) begin
            report_valid_d = 1'b0;
            state_d        = S_LATCHED;
          end
        end
        S_LATCHED: begin
          state_d = S_LATCHED;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= 16'd0;
      stamp_q        <= '0;
      onset_q        <= '0;
      report_valid_q <= 1'b0;
      report_data_q  <= '0;
      detected_q     <= 1'b0;
      count_q        <= 8'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stamp_q        <= stamp_d;
      onset_q        <= onset_d;
      report_valid_q <= report_valid_d;
      report_data_q  <= report_data_d;
      detected_q     <= detected_d;
      count_q        <= count_d;
    end
  end

  assign report_valid      = report_valid_q;
  assign report_data       = report_data_q;
  assign deadlock_detected = detected_q;
  assign deadlock_count    = count_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_hls_sobel_deadlock_report_ctrl.sv
// Directed self-checking bench for hls_sobel_deadlock_report_ctrl
// with an 8-cycle confirm window.
module tb_hls_sobel_deadlock_report_ctrl;

  localparam int NUM_PROC = 7;
  localparam int NUM_AXIS = 4;
  localparam int CONFIRM  = 8;
  localparam int STAMP_W  = 32;
  localparam int DATA_W   = STAMP_W + NUM_AXIS + 3*NUM_PROC;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  enable;
  logic                  clear;
  logic                  block_in;
  logic [2*NUM_PROC-1:0] inst_idle_sigs;
  logic [NUM_PROC-1:0]   inst_block_sigs;
  logic [NUM_AXIS-1:0]   axis_block_sigs;
  logic                  report_valid;
  logic                  report_ready;
  logic [DATA_W-1:0]     report_data;
  logic                  deadlock_detected;
  logic [7:0]            deadlock_count;
  logic [2:0]            state_dbg;

  int                    errors = 0;
  int                    checks = 0;
  logic [STAMP_W-1:0]    tb_stamp;
  logic [STAMP_W-1:0]    exp_onset;
  logic [DATA_W-1:0]     exp_data;
  int                    exp_count;
  int                    guard;

  hls_sobel_deadlock_report_ctrl #(
    .NUM_PROC(NUM_PROC), .NUM_AXIS(NUM_AXIS),
    .CONFIRM_CYCLES(CONFIRM), .STAMP_W(STAMP_W)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .block_in(block_in), .inst_idle_sigs(inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs), .axis_block_sigs(axis_block_sigs),
    .report_valid(report_valid), .report_ready(report_ready),
    .report_data(report_data), .deadlock_detected(deadlock_detected),
    .deadlock_count(deadlock_count), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // Reference free-running cycle stamp: value shown is what the next edge samples.
  always @(posedge clock) begin
    if (reset) tb_stamp <= '0;
    else       tb_stamp <= tb_stamp + 1;
  end

  task automatic applyStimulus(input logic en, input logic clr, input logic blk, input logic rdy);
    enable       = en;
    clear        = clr;
    block_in     = blk;
    report_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    inst_idle_sigs  = '0;
    inst_block_sigs = '0;
    axis_block_sigs = '0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_valid", 64'(report_valid), 64'd0);
    checkOutput("rst_data", 64'(report_data), 64'd0);
    checkOutput("rst_det", 64'(deadlock_detected), 64'd0);
    checkOutput("rst_count", 64'(deadlock_count), 64'd0);
    checkOutput("rst_state", 64'(state_dbg), 64'd0);
    reset = 1'b0;

    // Test 1: burst of exactly CONFIRM edges starting at stamp 100
    $display("[TB] test 1: basic confirm");
    inst_idle_sigs  = 14'h3FFF;
    inst_block_sigs = 7'h00;
    axis_block_sigs = 4'b1000;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_monitor", 64'(state_dbg), 64'd1);
    guard = 0;
    while (tb_stamp != 32'd100 && guard < 200) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    exp_onset = tb_stamp;
    repeat (CONFIRM - 1) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("t1_novalid_early", 64'(report_valid), 64'd0);
    checkOutput("t1_confirm_state", 64'(state_dbg), 64'd2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    exp_data = {32'd100, 4'b1000, 7'h00, 14'h3FFF};
    checkOutput("t1_valid", 64'(report_valid), 64'd1);
    checkOutput("t1_onset", 64'(exp_onset), 64'd100);
    checkOutput("t1_data", 64'(report_data), 64'(exp_data));
    checkOutput("t1_det", 64'(deadlock_detected), 64'd1);
    checkOutput("t1_count", 64'(deadlock_count), 64'd1);
    checkOutput("t1_state", 64'(state_dbg), 64'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("t1_accept_valid", 64'(report_valid), 64'd0);
    checkOutput("t1_accept_state", 64'(state_dbg), 64'd4);

    // Test 2: a 7-edge burst broken by one low edge must not report
    $display("[TB] test 2: broken burst");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_clear_det", 64'(deadlock_detected), 64'd0);
    checkOutput("t2_clear_state", 64'(state_dbg), 64'd1);
    checkOutput("t2_clear_count", 64'(deadlock_count), 64'd1);
    repeat (CONFIRM - 1) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_gap_state", 64'(state_dbg), 64'd1);
    checkOutput("t2_gap_valid", 64'(report_valid), 64'd0);
    inst_idle_sigs  = 14'h0155;
    inst_block_sigs = 7'h2A;
    axis_block_sigs = 4'b0101;
    exp_onset = tb_stamp;
    repeat (CONFIRM) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    exp_data = {exp_onset, 4'b0101, 7'h2A, 14'h0155};
    checkOutput("t2_valid", 64'(report_valid), 64'd1);
    checkOutput("t2_data", 64'(report_data), 64'(exp_data));
    checkOutput("t2_count", 64'(deadlock_count), 64'd2);

    // Test 3 (+ test 5 enable part): stalled consumer, inputs wiggle, enable dropped
    $display("[TB] test 3: back-pressure hold");
    for (int i = 0; i < 20; i++) begin
      inst_idle_sigs  = 14'(i * 37);
      axis_block_sigs = 4'(i);
      applyStimulus((i % 3) != 0, 1'b0, i[0], 1'b0);
      checkOutput("t3_hold_valid", 64'(report_valid), 64'd1);
      checkOutput("t3_hold_data", 64'(report_data), 64'(exp_data));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_accept_valid", 64'(report_valid), 64'd0);
    checkOutput("t3_accept_state", 64'(state_dbg), 64'd4);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, i[0], 1'b0);
    checkOutput("t3_latched_valid", 64'(report_valid), 64'd0);
    checkOutput("t3_latched_state", 64'(state_dbg), 64'd4);
    checkOutput("t3_latched_det", 64'(deadlock_detected), 64'd1);
    checkOutput("t3_latched_count", 64'(deadlock_count), 64'd2);

    // Test 4: clear with block_in high in the same edge; confirm starts one edge later
    $display("[TB] test 4: clear vs block");
    inst_idle_sigs  = 14'h2AAA;
    inst_block_sigs = 7'h41;
    axis_block_sigs = 4'b0011;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_clear_det", 64'(deadlock_detected), 64'd0);
    checkOutput("t4_clear_state", 64'(state_dbg), 64'd1);
    exp_onset = tb_stamp;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_confirm_state", 64'(state_dbg), 64'd2);
    checkOutput("t4_count_held", 64'(deadlock_count), 64'd2);
    repeat (CONFIRM - 2) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_novalid_early", 64'(report_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    exp_data = {exp_onset, 4'b0011, 7'h41, 14'h2AAA};
    checkOutput("t4_valid", 64'(report_valid), 64'd1);
    checkOutput("t4_data", 64'(report_data), 64'(exp_data));
    checkOutput("t4_count", 64'(deadlock_count), 64'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_zero_wait_valid", 64'(report_valid), 64'd0);
    checkOutput("t4_zero_wait_state", 64'(state_dbg), 64'd4);

    // Test 5: reset while confirming
    $display("[TB] test 5: reset mid-confirm");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("t5_pre_state", 64'(state_dbg), 64'd2);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("t5_valid", 64'(report_valid), 64'd0);
    checkOutput("t5_data", 64'(report_data), 64'd0);
    checkOutput("t5_det", 64'(deadlock_detected), 64'd0);
    checkOutput("t5_count", 64'(deadlock_count), 64'd0);
    checkOutput("t5_state", 64'(state_dbg), 64'd0);
    reset = 1'b0;

    // Test 6: repeated confirm/clear until the counter saturates
    $display("[TB] test 6: count saturation");
    for (int i = 0; i < 256; i++) begin
      guard = 0;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      while (!report_valid && guard < 20) begin
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        guard++;
      end
      if (!report_valid) begin
        checkOutput("t6_timeout", 64'(report_valid), 64'd1);
        break;
      end
      exp_count = (i + 1 > 255) ? 255 : i + 1;
      checkOutput("t6_count", 64'(deadlock_count), 64'(exp_count));
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("t6_final_count", 64'(deadlock_count), 64'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
